// File: rtl/fetch_defs.sv
// Shared definitions for the instruction-fetch sequencer: FSM state encoding and default widths.
package fetch_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_e;

  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_INSTR_W   = 8;
  localparam int unsigned DEF_MEM_DEPTH = 32;
  localparam int unsigned PERF_W        = 16;

endpackage

// File: rtl/imem_fetch_seq_if.sv
// Memory bus plus decoder-side valid/ready handshake of the fetch sequencer.
interface imem_fetch_seq_if
  import fetch_defs::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
);
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_clear;
  logic [INSTR_W-1:0] imem_instr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_addr, imem_clear, out_valid, out_instr, out_pc,
    input  imem_instr, out_ready
  );

  modport slave (
    input  imem_addr, imem_clear, out_valid, out_instr, out_pc,
    output imem_instr, out_ready
  );
endinterface

// File: rtl/fetch_out_stage.sv
// One-deep valid/ready holding register for fetched words; flush beats load beats accept.
module fetch_out_stage
  import fetch_defs::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               accept_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (accept_i && valid_q) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the data registers are reset as well, so out_instr/out_pc read zero after reset.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/imem_fetch_seq.sv
// Fetch sequencer: owns the PC, drives the instruction memory and feeds a one-deep output stage.
// Optional performance counters are enabled with the IMEM_FETCH_PERF_EN macro.
module imem_fetch_seq
  import fetch_defs::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned INSTR_W   = DEF_INSTR_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  imem_fetch_seq_if.master   bus,
  output logic               busy,
  output logic               halted,
  output logic               fault
`ifdef IMEM_FETCH_PERF_EN
  , output logic [PERF_W-1:0] fetch_count
  , output logic [PERF_W-1:0] stall_count
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              load, flush, out_valid, in_range;

  assign in_range = 32'(pc_q) < MEM_DEPTH;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (redirect_valid) pc_d = redirect_addr;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALTED;
          flush   = 1'b1;
        end else if (redirect_valid) begin
          pc_d  = redirect_addr;
          flush = 1'b1;
        end else if (!in_range) begin
          // The faulting PC stays on imem_addr; a held word may still drain.
          state_d = FAULT;
        end else if (!out_valid || bus.out_ready) begin
          load = 1'b1;
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_out_stage #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_out_stage (
    .clk      (clk),
    .clear_n  (clear_n),
    .load_i   (load),
    .flush_i  (flush),
    .accept_i (bus.out_ready),
    .instr_i  (bus.imem_instr),
    .pc_i     (pc_q),
    .valid_o  (out_valid),
    .instr_o  (bus.out_instr),
    .pc_o     (bus.out_pc)
  );

  assign bus.out_valid  = out_valid;
  assign bus.imem_addr  = pc_q;
  assign bus.imem_clear = (state_q != RUN);
  assign busy           = (state_q == RUN);
  assign halted         = (state_q == HALTED);
  assign fault          = (state_q == FAULT);

`ifdef IMEM_FETCH_PERF_EN
  logic [PERF_W-1:0] fetch_cnt_q, stall_cnt_q;
  logic              stall_cycle;

  assign stall_cycle = (state_q == RUN) && out_valid && !bus.out_ready;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load && (fetch_cnt_q != '1))        fetch_cnt_q <= fetch_cnt_q + PERF_W'(1);
      if (stall_cycle && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_imem_fetch_seq.sv
// Self-checking bench for imem_fetch_seq: directed test-plan scenarios plus a randomized run
// compared cycle by cycle against a transaction-level reference model.
module tb_imem_fetch_seq;

  logic       clk = 1'b0;
  logic       clear_n = 1'b1;
  logic       start = 1'b0;
  logic       halt_req = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
  logic       busy, halted, fault;
`ifdef IMEM_FETCH_PERF_EN
  logic [15:0] fetch_count, stall_count;
`endif

  logic [7:0] mem [32];
  int n_tests = 0;
  int n_fail  = 0;

  imem_fetch_seq_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

  // Combinational-read instruction memory; out-of-range addresses read zero.
  assign bus.imem_instr = (bus.imem_addr < 8'd32) ? mem[bus.imem_addr[4:0]] : 8'h00;

  imem_fetch_seq #(
    .ADDR_W(8), .INSTR_W(8), .MEM_DEPTH(32), .RESET_PC(0)
  ) dut (
    .clk            (clk),
    .clear_n        (clear_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (bus),
    .busy           (busy),
    .halted         (halted),
    .fault          (fault)
`ifdef IMEM_FETCH_PERF_EN
    , .fetch_count  (fetch_count)
    , .stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clear_n = 1'b0;
    start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    #1 clear_n = 1'b0;
    #2;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0h exp=0", bus.out_valid); end
    n_tests++; if (bus.out_instr !== 8'h00) begin n_fail++; $display("FAIL reset_out_instr got=%0h exp=0", bus.out_instr); end
    n_tests++; if (bus.out_pc !== 8'h00) begin n_fail++; $display("FAIL reset_out_pc got=%0h exp=0", bus.out_pc); end
    n_tests++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_imem_addr got=%0h exp=0", bus.imem_addr); end
    n_tests++; if (bus.imem_clear !== 1'b1) begin n_fail++; $display("FAIL reset_imem_clear got=%0h exp=1", bus.imem_clear); end
    n_tests++; if ({busy, halted, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_status got=%b exp=000", {busy, halted, fault}); end
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [7:0] exp_w [3];
    exp_w = '{8'h47, 8'h59, 8'h7D};
    bus.out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n_tests++; if ({busy, bus.imem_clear, bus.out_valid} !== 3'b100) begin n_fail++; $display("FAIL run_entry got=%b exp=100", {busy, bus.imem_clear, bus.out_valid}); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if ({bus.out_valid, bus.out_instr, bus.out_pc} !== {1'b1, exp_w[i], 8'(i)}) begin
        n_fail++; $display("FAIL stream_word%0d got=%b/%h/%0d exp=1/%h/%0d", i, bus.out_valid, bus.out_instr, bus.out_pc, exp_w[i], i);
      end
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if ({bus.out_valid, bus.out_instr, bus.out_pc, bus.imem_addr} !== {1'b1, 8'h7D, 8'd2, 8'd3}) begin
        n_fail++; $display("FAIL backpressure_hold%0d got=%b/%h/%0d/%0d exp=1/7d/2/3", i, bus.out_valid, bus.out_instr, bus.out_pc, bus.imem_addr);
      end
    end
    bus.out_ready = 1'b1;
    step();
    n_tests++; if ({bus.out_valid, bus.out_instr, bus.out_pc} !== {1'b1, 8'h71, 8'd3}) begin
      n_fail++; $display("FAIL backpressure_release got=%b/%h/%0d exp=1/71/3", bus.out_valid, bus.out_instr, bus.out_pc);
    end
  endtask

  task automatic test_redirect();
    bus.out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 8'd6;
    step();
    redirect_valid = 1'b0;
    n_tests++; if ({bus.out_valid, bus.imem_addr} !== {1'b0, 8'd6}) begin
      n_fail++; $display("FAIL redirect_drop got=%b/%0d exp=0/6", bus.out_valid, bus.imem_addr);
    end
    bus.out_ready = 1'b1;
    step();
    n_tests++; if ({bus.out_valid, bus.out_instr, bus.out_pc} !== {1'b1, 8'h6D, 8'd6}) begin
      n_fail++; $display("FAIL redirect_target got=%b/%h/%0d exp=1/6d/6", bus.out_valid, bus.out_instr, bus.out_pc);
    end
    bus.out_ready = 1'b0;
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'd2;
    step();
    halt_req = 1'b0; redirect_valid = 1'b0;
    n_tests++; if ({halted, busy, bus.out_valid, bus.imem_addr} !== {3'b100, 8'd7}) begin
      n_fail++; $display("FAIL halt_beats_redirect got=%b/%0d exp=100/7", {halted, busy, bus.out_valid}, bus.imem_addr);
    end
  endtask

  task automatic test_halt_resume();
    redirect_valid = 1'b1; redirect_addr = 8'd4;
    step();
    redirect_valid = 1'b0;
    n_tests++; if ({halted, bus.imem_addr} !== {1'b1, 8'd4}) begin
      n_fail++; $display("FAIL halted_redirect got=%b/%0d exp=1/4", halted, bus.imem_addr);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    halt_req = 1'b1;
    bus.out_ready = 1'b1;
    step();
    halt_req = 1'b0;
    n_tests++; if ({halted, bus.out_valid, bus.imem_addr} !== {2'b10, 8'd4}) begin
      n_fail++; $display("FAIL halt_at_pc4 got=%b/%0d exp=10/4", {halted, bus.out_valid}, bus.imem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++; if ({halted, bus.out_valid} !== 2'b10) begin
        n_fail++; $display("FAIL halt_gap%0d got=%b exp=10", i, {halted, bus.out_valid});
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_tests++; if ({busy, bus.out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL resume_entry got=%b exp=10", {busy, bus.out_valid});
    end
    step();
    n_tests++; if ({bus.out_valid, bus.out_instr, bus.out_pc} !== {1'b1, 8'h5D, 8'd4}) begin
      n_fail++; $display("FAIL resume_word got=%b/%h/%0d exp=1/5d/4", bus.out_valid, bus.out_instr, bus.out_pc);
    end
  endtask

  task automatic test_fault();
    bus.out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 8'd30;
    step();
    redirect_valid = 1'b0;
    for (int i = 30; i < 32; i++) begin
      step();
      n_tests++; if ({bus.out_valid, bus.out_instr, bus.out_pc} !== {1'b1, mem[i], 8'(i)}) begin
        n_fail++; $display("FAIL tail_word%0d got=%b/%h/%0d exp=1/%h/%0d", i, bus.out_valid, bus.out_instr, bus.out_pc, mem[i], i);
      end
    end
    step();
    n_tests++; if ({fault, busy, bus.imem_clear, bus.out_valid, bus.imem_addr} !== {4'b1010, 8'd32}) begin
      n_fail++; $display("FAIL fault_entry got=%b/%0d exp=1010/32", {fault, busy, bus.imem_clear, bus.out_valid}, bus.imem_addr);
    end
    start = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'd0;
    step();
    step();
    start = 1'b0; redirect_valid = 1'b0;
    n_tests++; if ({fault, busy, bus.out_valid, bus.imem_addr} !== {3'b100, 8'd32}) begin
      n_fail++; $display("FAIL fault_sticky got=%b/%0d exp=100/32", {fault, busy, bus.out_valid}, bus.imem_addr);
    end
    @(negedge clk);
    clear_n = 1'b0;
    #2;
    n_tests++; if ({fault, busy, halted, bus.imem_addr} !== {3'b000, 8'd0}) begin
      n_fail++; $display("FAIL fault_clear got=%b/%0d exp=000/0", {fault, busy, halted}, bus.imem_addr);
    end
    @(negedge clk);
    clear_n = 1'b1;
    step();
    n_tests++; if ({fault, busy, halted, bus.imem_clear} !== 4'b0001) begin
      n_fail++; $display("FAIL idle_after_clear got=%b exp=0001", {fault, busy, halted, bus.imem_clear});
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL async_pre got=%0h exp=1", bus.out_valid); end
    #2 clear_n = 1'b0;
    #1;
    n_tests++; if ({bus.out_valid, bus.imem_clear, busy} !== 3'b010) begin
      n_fail++; $display("FAIL async_reset got=%b exp=010", {bus.out_valid, bus.imem_clear, busy});
    end
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  typedef enum {M_IDLE, M_RUN, M_HALTED, M_FAULT} m_state_t;

  task automatic test_random();
    m_state_t   m_state = M_IDLE;
    int         m_pc = 0, m_hpc = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_instr = 8'h00;
    int         m_fetch = 0, m_stall = 0;
    bit         hs;
    logic [3:0] exp_status;
    for (int i = 9; i < 32; i++) mem[i] = 8'($urandom);
    pulse_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      start          = ($urandom % 4) == 0;
      halt_req       = ($urandom % 12) == 0;
      redirect_valid = (($urandom % 8) == 0) || (m_state == M_RUN && m_pc >= 28);
      redirect_addr  = 8'($urandom_range(0, 27));
      bus.out_ready  = ($urandom % 3) != 0;
      hs = m_valid && bus.out_ready;
      if (m_state == M_RUN && m_valid && !bus.out_ready) m_stall++;
      step();
      case (m_state)
        M_IDLE, M_HALTED: begin
          if (redirect_valid) m_pc = int'(redirect_addr);
          if (start) m_state = M_RUN;
          if (hs) m_valid = 1'b0;
        end
        M_RUN: begin
          if (halt_req) begin
            m_state = M_HALTED; m_valid = 1'b0;
          end else if (redirect_valid) begin
            m_pc = int'(redirect_addr); m_valid = 1'b0;
          end else if (m_pc >= 32) begin
            m_state = M_FAULT;
            if (hs) m_valid = 1'b0;
          end else if (!m_valid || bus.out_ready) begin
            m_valid = 1'b1; m_hpc = m_pc; m_instr = mem[m_pc];
            m_pc = (m_pc + 1) % 256; m_fetch++;
          end
        end
        default: if (hs) m_valid = 1'b0;
      endcase
      exp_status = {m_state == M_RUN, m_state == M_HALTED, m_state == M_FAULT, m_state != M_RUN};
      n_tests++; if ({busy, halted, fault, bus.imem_clear} !== exp_status) begin
        n_fail++; $display("FAIL rnd_status cyc=%0d got=%b exp=%b", cyc, {busy, halted, fault, bus.imem_clear}, exp_status);
      end
      n_tests++; if (bus.imem_addr !== 8'(m_pc)) begin
        n_fail++; $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", cyc, bus.imem_addr, m_pc);
      end
      n_tests++; if (bus.out_valid !== m_valid) begin
        n_fail++; $display("FAIL rnd_valid cyc=%0d got=%0h exp=%0h", cyc, bus.out_valid, m_valid);
      end
      if (m_valid) begin
        n_tests++; if ({bus.out_pc, bus.out_instr} !== {8'(m_hpc), m_instr}) begin
          n_fail++; $display("FAIL rnd_data cyc=%0d got=%0d/%h exp=%0d/%h", cyc, bus.out_pc, bus.out_instr, m_hpc, m_instr);
        end
      end
    end
`ifdef IMEM_FETCH_PERF_EN
    n_tests++; if (fetch_count !== 16'(m_fetch)) begin n_fail++; $display("FAIL perf_fetch got=%0d exp=%0d", fetch_count, m_fetch); end
    n_tests++; if (stall_count !== 16'(m_stall)) begin n_fail++; $display("FAIL perf_stall got=%0d exp=%0d", stall_count, m_stall); end
`endif
    start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [9];
    prog = '{8'h47, 8'h59, 8'h7D, 8'h71, 8'h5D, 8'h59, 8'h6D, 8'h71, 8'hC3};
    for (int i = 0; i < 32; i++) mem[i] = (i < 9) ? prog[i] : 8'($urandom);
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_redirect();
    test_halt_resume();
    test_fault();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_seq.md
Name: imem_fetch_seq

Overview:
- Fetch sequencer for the 8-bit instruction memory (combinational read, 32 words, `address`/`clear`/`instruction` interface).
- Owns the program counter and drives the memory address.
- Registers each fetched word into a one-deep output stage with a valid/ready handshake to the decoder.
- Handles start, halt, branch redirect and out-of-range fetch faults.

Parameters:
- ADDR_W, 8: width of the PC and memory address.
- INSTR_W, 8: instruction width.
- MEM_DEPTH, 32: number of populated memory words. A fetch from address >= MEM_DEPTH is a fault.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  input  1  single clock, rising edge.
- clear_n  input  1  asynchronous active-low reset.
- start  input  1  begin or resume fetching.
- halt_req  input  1  stop fetching.
- redirect_valid  input  1  load a new PC (branch or jump).
- redirect_addr  input  ADDR_W  new PC value.
- imem_addr  output  ADDR_W  address to the instruction memory; equals the PC register.
- imem_clear  output  1  drives the memory `clear` input; high whenever state != RUN.
- imem_instr  input  INSTR_W  instruction read from memory in the same cycle.
- out_valid  output  1  output stage holds an instruction.
- out_ready  input  1  decoder accepts the instruction.
- out_instr  output  INSTR_W  registered instruction.
- out_pc  output  ADDR_W  address the instruction was fetched from.
- busy  output  1  state == RUN.
- halted  output  1  state == HALTED.
- fault  output  1  state == FAULT.

Behaviour:
- Reset (clear_n low, asynchronous):
  - state = IDLE, pc = RESET_PC.
  - out_valid = 0, out_instr = 0, out_pc = 0.
  - busy, halted and fault = 0; imem_clear = 1.
- Reset asserted mid-operation discards any held instruction immediately.
- States: IDLE, RUN, HALTED, FAULT.
- IDLE:
  - redirect_valid loads pc.
  - start moves the block to RUN at the next edge.
  - If both are high in the same cycle, pc = redirect_addr and state = RUN.
- RUN, one decision per edge, in this priority order:
  1. halt_req: state to HALTED; pc held. out_valid clears unless the held word is accepted this cycle (then it also clears). No capture.
  2. redirect_valid: pc = redirect_addr. out_valid = 0 (the held word is dropped unless out_valid && out_ready this cycle). No capture.
  3. pc >= MEM_DEPTH: state to FAULT, no capture. out_valid clears after any handshake that completes this cycle.
  4. Load condition (!out_valid || out_ready): out_instr = imem_instr, out_pc = pc, out_valid = 1, pc = pc + 1 modulo 2^ADDR_W.
  5. Otherwise (stall): everything holds.
- Timing and throughput:
  - First out_valid goes high one edge after entering RUN.
  - Throughput is one instruction per cycle while out_ready is held high.
  - A handshake completes on any edge where out_valid && out_ready.
- HALTED:
  - start returns to RUN with pc unchanged.
  - redirect_valid loads pc.
  - halt_req is ignored.
- FAULT: sticky; only clear_n exits. The pc that faulted stays visible on imem_addr.
- out_instr and out_pc must stay stable while out_valid && !out_ready.

Optional Feature:
- Macro: IMEM_FETCH_PERF_EN.
- When defined, two extra outputs are added:
  - fetch_count[15:0]: +1 on each capture.
  - stall_count[15:0]: +1 on each RUN cycle with out_valid && !out_ready.
- Both counters saturate at 16'hFFFF and reset to 0.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared include/package `fetch_defs`:
  - state encodings: IDLE=2'd0, RUN=2'd1, HALTED=2'd2, FAULT=2'd3.
  - default ADDR_W, INSTR_W, MEM_DEPTH.
- One natural sub-module: `fetch_out_stage`. It is the one-deep valid/ready holding register, with load, flush, and accept inputs plus instr/pc data.
- The FSM and PC stay in the top module.

Test Plan:
- Words 0..8 = 0x47, 0x59, 0x7D, 0x71, 0x5D, 0x59, 0x6D, 0x71, 0xC3; reset, then start, out_ready=1 -> out_instr 0x47, 0x59, 0x7D ... on consecutive cycles with out_pc 0, 1, 2 ...; first valid exactly 1 cycle after RUN.
- Backpressure: out_ready=0 for 3 cycles while holding word 2 -> out_instr stays 0x7D, out_pc stays 2, imem_addr stays 3; on release the next capture is 0x71.
- Redirect to 6 while word 3 is held and unaccepted -> word 3 dropped; next out_valid carries 0x6D with out_pc 6. Repeat with redirect and halt_req in the same cycle -> HALTED wins and pc is unchanged.
- halt_req at pc=4, then start 5 cycles later -> halted=1 during the gap, no out_valid; resume delivers 0x5D from pc 4.
- Redirect to 30 and run -> words 30 and 31 delivered; at pc=32, fault=1, no further out_valid; start and redirect are ignored; clear_n pulse -> IDLE, pc=0, fault=0.
- Assert clear_n low mid-stream with out_valid=1 -> out_valid=0 and imem_clear=1 immediately (asynchronous), without waiting for a clock edge.
